// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package mips_pkg;

  localparam int XLEN   = 32;
  localparam int IMM_W  = 16;
  localparam int JIDX_W = 26;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID
  } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC select: jump over branch over sequential.
// Misaligned branch targets are forced to word alignment.
module pc_next
  import mips_pkg::*;
(
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  output logic [XLEN-1:0]   next_pc,
  output logic              misaligned
);

  always_comb begin
    next_pc    = pc_plus4;
    misaligned = 1'b0;
    priority case (1'b1)
      jump: begin
        next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      end
      branch_taken: begin
        next_pc    = {branch_target[31:2], 2'b00};
        misaligned = |branch_target[1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: IDLE/FETCH/VALID handshake with imem,
// holding instr under stall and redirecting on the consume edge.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  output logic [XLEN-1:0]   instr,
  output logic              instr_valid,
  output logic [IMM_W-1:0]  imm16,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              align_err
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            align_q, align_d;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  assign pc_plus4 = pc_q + 32'd4;

  pc_next u_pc_next (
    .pc_plus4      (pc_plus4),
    .jump          (jump),
    .jump_index    (jump_index),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (next_pc),
    .misaligned    (misaligned)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    align_d = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        // redirect inputs matter only on the consume edge
        if (!stall) begin
          pc_d    = next_pc;
          align_d = misaligned;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      align_q <= align_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == VALID);
  assign instr       = instr_q;
  assign imm16       = instr_q[IMM_W-1:0];
  assign pc          = pc_q;
  assign align_err   = align_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Table-driven bench for instr_fetch with an instr/pc scoreboard.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] imm16;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        align_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .imm16         (imm16),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .align_err     (align_err)
  );

  typedef struct {
    logic [31:0] rdata;
    int          delay;
    int          stall_n;
    logic        jmp;
    logic [25:0] jidx;
    logic        br;
    logic [31:0] btgt;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
    logic        exp_align;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } sb_t;

  vec_t v[8];
  sb_t  sbq[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (imem_req !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic idle_inputs();
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_index    = 26'h0;
  endtask

  initial begin
    sb_t s;
    logic [31:0] held_instr;
    v[0] = '{32'h2008_FFFF, 0, 0, 1'b0, 26'h0, 1'b0, 32'h0,
             32'h0000_0000, 32'h0000_0004, 1'b0};
    v[1] = '{32'h8C22_0004, 3, 0, 1'b0, 26'h0, 1'b1, 32'h0040_0010,
             32'h0000_0004, 32'h0040_0010, 1'b0};
    v[2] = '{32'h0800_0040, 0, 0, 1'b1, 26'h000_0040, 1'b1, 32'h0000_1230,
             32'h0040_0010, 32'h0000_0100, 1'b0};
    v[3] = '{32'h1234_5678, 0, 5, 1'b0, 26'h0, 1'b0, 32'h0,
             32'h0000_0100, 32'h0000_0104, 1'b0};
    v[4] = '{32'h1000_FFFE, 1, 0, 1'b0, 26'h0, 1'b1, 32'h0000_0102,
             32'h0000_0104, 32'h0000_0100, 1'b1};
    v[5] = '{32'hAAAA_5555, 0, 1, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC,
             32'h0000_0100, 32'hFFFF_FFFC, 1'b0};
    v[6] = '{32'h0000_0000, 2, 0, 1'b0, 26'h0, 1'b0, 32'h0,
             32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    v[7] = '{32'h3C01_8000, 0, 2, 1'b1, 26'h3FF_FFFF, 1'b0, 32'h0,
             32'h0000_0000, 32'h0FFF_FFFC, 1'b0};

    idle_inputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_align", {31'd0, align_err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);

    for (int i = 0; i < 8; i++) begin
      wait_req(10);
      check($sformatf("v%0d_addr", i), imem_addr, v[i].exp_pc);
      for (int d = 0; d < v[i].delay; d++) begin
        imem_ack = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_wait_req", i), {31'd0, imem_req}, 32'd1);
        check($sformatf("v%0d_wait_addr", i), imem_addr, v[i].exp_pc);
      end
      imem_ack   = 1'b1;
      imem_rdata = v[i].rdata;
      sbq.push_back('{v[i].rdata, v[i].exp_pc});
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      check($sformatf("v%0d_valid", i), {31'd0, instr_valid}, 32'd1);
      check($sformatf("v%0d_req_off", i), {31'd0, imem_req}, 32'd0);
      if (instr_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          check($sformatf("v%0d_sb_empty", i), 32'd0, 32'd1);
        end else begin
          s = sbq.pop_front();
          check($sformatf("v%0d_instr", i), instr, s.instr);
          check($sformatf("v%0d_pc", i), pc, s.pc);
          check($sformatf("v%0d_imm16", i), {16'd0, imm16},
                {16'd0, s.instr[15:0]});
          check($sformatf("v%0d_pc4", i), pc_plus4, s.pc + 32'd4);
        end
      end
      held_instr = instr;
      for (int k = 0; k < v[i].stall_n; k++) begin
        stall         = 1'b1;
        jump          = 1'b1;
        jump_index    = 26'($urandom);
        branch_taken  = 1'b1;
        branch_target = $urandom;
        imem_ack      = 1'b1;
        imem_rdata    = $urandom;
        @(negedge clk);
        check($sformatf("v%0d_st_valid", i), {31'd0, instr_valid}, 32'd1);
        check($sformatf("v%0d_st_req", i), {31'd0, imem_req}, 32'd0);
        check($sformatf("v%0d_st_instr", i), instr, held_instr);
        check($sformatf("v%0d_st_pc", i), pc, v[i].exp_pc);
      end
      stall         = 1'b0;
      imem_ack      = 1'b0;
      imem_rdata    = 32'h0;
      jump          = v[i].jmp;
      jump_index    = v[i].jidx;
      branch_taken  = v[i].br;
      branch_target = v[i].btgt;
      @(negedge clk);
      idle_inputs();
      check($sformatf("v%0d_next_req", i), {31'd0, imem_req}, 32'd1);
      check($sformatf("v%0d_next_addr", i), imem_addr, v[i].exp_next);
      check($sformatf("v%0d_align", i), {31'd0, align_err},
            {31'd0, v[i].exp_align});
      @(negedge clk);
      check($sformatf("v%0d_align_end", i), {31'd0, align_err}, 32'd0);
      check($sformatf("v%0d_hold_addr", i), imem_addr, v[i].exp_next);
    end

    // reset in the middle of a fetch, with a late ack
    check("pre_rst_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("in_rst_valid", {31'd0, instr_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, 32'h0);
    check("restart_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    check("restart_wait", {31'd0, instr_valid}, 32'd0);
    check("sb_drained", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
